// File: rtl/conv_window_sequencer.sv
// Raster pixel stream to 3x3 convolution window sequencer with two line buffers.
// Optional stall counter enabled by defining CONV_SEQ_STALL_CNT_EN.
module conv_window_sequencer #(
    parameter int IMAGE_WIDTH  = 512,
    parameter int IMAGE_HEIGHT = 512,
    parameter int PIXEL_W      = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            pix_valid,
    output logic                            pix_ready,
    input  logic [PIXEL_W-1:0]              pix_data,
    output logic                            win_valid,
    input  logic                            win_ready,
    output logic [9*PIXEL_W-1:0]            win_data,
    output logic [$clog2(IMAGE_HEIGHT)-1:0] win_row,
    output logic [$clog2(IMAGE_WIDTH)-1:0]  win_col,
    output logic                            busy,
    output logic                            frame_done,
    output logic [31:0]                     stall_cycles
);

    localparam int RW = $clog2(IMAGE_HEIGHT);
    localparam int CW = $clog2(IMAGE_WIDTH);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMAGE_HEIGHT - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(IMAGE_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [RW-1:0]                row;
    logic [CW-1:0]                col;
    logic                         last_accepted;
    logic                         accept;
    logic                         emit;
    logic                         start_ok;
    logic                         out_free;

    logic [PIXEL_W-1:0]           lb0 [IMAGE_WIDTH];
    logic [PIXEL_W-1:0]           lb1 [IMAGE_WIDTH];
    logic [PIXEL_W-1:0]           tap_lb0;
    logic [PIXEL_W-1:0]           tap_lb1;

    logic [2:0][2:0][PIXEL_W-1:0] shift_win;
    logic [2:0][2:0][PIXEL_W-1:0] shift_next;
    logic [9*PIXEL_W-1:0]         win_flat;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    assign out_free = !win_valid || win_ready;

    always_comb begin
        state_next = state;
        pix_ready  = 1'b0;
        busy       = 1'b0;
        frame_done = 1'b0;
        start_ok   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_RUN;
                    start_ok   = 1'b1;
                end
            end
            S_RUN: begin
                busy      = 1'b1;
                pix_ready = !last_accepted && out_free;
                // Leave RUN only once the final window has been handed off.
                if (last_accepted && out_free) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                frame_done = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign accept = pix_valid && pix_ready;
    assign emit   = accept && (row >= RW'(2)) && (col >= CW'(2));

    always_comb begin
        tap_lb0 = lb0[col];
        tap_lb1 = lb1[col];
    end

    always_comb begin
        shift_next = shift_win;
        for (int unsigned r = 0; r < 3; r++) begin
            shift_next[r][0] = shift_win[r][1];
            shift_next[r][1] = shift_win[r][2];
        end
        shift_next[0][2] = tap_lb1;
        shift_next[1][2] = tap_lb0;
        shift_next[2][2] = pix_data;
    end

    always_comb begin
        win_flat = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            for (int unsigned j = 0; j < 3; j++) begin
                win_flat[(i*3+j)*PIXEL_W +: PIXEL_W] = shift_next[i][j];
            end
        end
    end

    // Line buffers are never read before being written in a frame, so no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1[col] <= tap_lb0;
            lb0[col] <= pix_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row           <= '0;
            col           <= '0;
            last_accepted <= 1'b0;
            shift_win     <= '0;
            win_valid     <= 1'b0;
            win_data      <= '0;
            win_row       <= '0;
            win_col       <= '0;
        end else begin
            if (start_ok) begin
                row           <= '0;
                col           <= '0;
                last_accepted <= 1'b0;
            end
            if (accept) begin
                shift_win <= shift_next;
                if (col == COL_LAST) begin
                    col <= '0;
                    if (row == ROW_LAST) begin
                        last_accepted <= 1'b1;
                    end else begin
                        row <= row + RW'(1);
                    end
                end else begin
                    col <= col + CW'(1);
                end
            end
            if (emit) begin
                win_valid <= 1'b1;
                win_data  <= win_flat;
                win_row   <= row - RW'(1);
                win_col   <= col - CW'(1);
            end else if (win_ready) begin
                win_valid <= 1'b0;
            end
        end
    end

`ifdef CONV_SEQ_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            stall_cycles <= '0;
        end else if (win_valid && !win_ready && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Scoreboard bench for conv_window_sequencer: a 4x4 instance for directed steps
// and a 5x6 instance so non-power-of-two row/column wrap is exercised.
module tb_conv_window_sequencer;

    localparam int PW  = 8;
    localparam int W_A = 4;
    localparam int H_A = 4;
    localparam int W_B = 5;
    localparam int H_B = 6;

    typedef struct {
        logic [9*PW-1:0] data;
        int              row;
        int              col;
    } win_t;

    logic            clk;
    logic            rst;
    logic            start_s;
    logic            pv;
    logic            wr;
    logic            sel;
    logic [PW-1:0]   pd;

    logic            a_pix_ready, a_win_valid, a_busy, a_frame_done;
    logic [9*PW-1:0] a_win_data;
    logic [1:0]      a_row, a_col;
    logic [31:0]     a_stall;

    logic            b_pix_ready, b_win_valid, b_busy, b_frame_done;
    logic [9*PW-1:0] b_win_data;
    logic [2:0]      b_row, b_col;
    logic [31:0]     b_stall;

    logic            o_pix_ready, o_win_valid, o_busy, o_frame_done;
    logic [9*PW-1:0] o_win_data;
    logic [31:0]     o_row, o_col, o_stall;

    int              n_total = 0;
    int              n_pass  = 0;
    int              n_fail  = 0;
    int              n_win   = 0;
    int              mr, mc, cur_w;
    bit              acc;
    logic [PW-1:0]   img [8][8];
    win_t            sb [$];
    logic [9*PW-1:0] held;

    conv_window_sequencer #(
        .IMAGE_WIDTH (W_A),
        .IMAGE_HEIGHT(H_A),
        .PIXEL_W     (PW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start_s && !sel),
        .pix_valid   (pv && !sel),
        .pix_ready   (a_pix_ready),
        .pix_data    (pd),
        .win_valid   (a_win_valid),
        .win_ready   (wr),
        .win_data    (a_win_data),
        .win_row     (a_row),
        .win_col     (a_col),
        .busy        (a_busy),
        .frame_done  (a_frame_done),
        .stall_cycles(a_stall)
    );

    conv_window_sequencer #(
        .IMAGE_WIDTH (W_B),
        .IMAGE_HEIGHT(H_B),
        .PIXEL_W     (PW)
    ) dut_b (
        .clk         (clk),
        .rst         (rst),
        .start       (start_s && sel),
        .pix_valid   (pv && sel),
        .pix_ready   (b_pix_ready),
        .pix_data    (pd),
        .win_valid   (b_win_valid),
        .win_ready   (wr),
        .win_data    (b_win_data),
        .win_row     (b_row),
        .win_col     (b_col),
        .busy        (b_busy),
        .frame_done  (b_frame_done),
        .stall_cycles(b_stall)
    );

    always_comb begin
        if (sel) begin
            o_pix_ready  = b_pix_ready;
            o_win_valid  = b_win_valid;
            o_busy       = b_busy;
            o_frame_done = b_frame_done;
            o_win_data   = b_win_data;
            o_row        = 32'(b_row);
            o_col        = 32'(b_col);
            o_stall      = b_stall;
        end else begin
            o_pix_ready  = a_pix_ready;
            o_win_valid  = a_win_valid;
            o_busy       = a_busy;
            o_frame_done = a_frame_done;
            o_win_data   = a_win_data;
            o_row        = 32'(a_row);
            o_col        = 32'(a_col);
            o_stall      = a_stall;
        end
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle: model the handshakes that the coming posedge will perform, then
    // advance to the next negedge where registered outputs are stable.
    task automatic step();
        win_t e;
        #1;
        acc = pv && o_pix_ready;
        if (acc) begin
            img[mr][mc] = pd;
            if (mr >= 2 && mc >= 2) begin
                e.row  = mr - 1;
                e.col  = mc - 1;
                e.data = '0;
                for (int i = 0; i < 3; i++) begin
                    for (int j = 0; j < 3; j++) begin
                        e.data[(i*3+j)*PW +: PW] = img[mr-2+i][mc-2+j];
                    end
                end
                sb.push_back(e);
            end
            if (mc == cur_w - 1) begin
                mc = 0;
                mr++;
            end else begin
                mc++;
            end
        end
        if (o_win_valid && wr) begin
            n_win++;
            chk("sb_has_entry", sb.size() != 0, 1'b1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("win_data", o_win_data, e.data);
                chk("win_row", o_row, e.row);
                chk("win_col", o_col, e.col);
            end
        end
        @(negedge clk);
    endtask

    task automatic begin_frame(input bit s);
        sel   = s;
        cur_w = s ? W_B : W_A;
        mr    = 0;
        mc    = 0;
        n_win = 0;
        sb.delete();
        pv      = 1'b0;
        wr      = 1'b1;
        start_s = 1'b1;
        step();
        start_s = 1'b0;
        chk("busy_after_start", o_busy, 1'b1);
    endtask

    task automatic feed(input int n, input int gap_pct, input int stall_pct,
                        input bit rnd_data, input int base);
        int sent  = 0;
        int guard = 0;
        while (sent < n && guard < 20000) begin
            pv = ($urandom_range(99) >= gap_pct);
            wr = ($urandom_range(99) >= stall_pct);
            pd = rnd_data ? PW'($urandom) : PW'(base + sent);
            step();
            if (acc) sent++;
            guard++;
        end
        pv = 1'b0;
        chk("feed_complete", sent, n);
    endtask

    task automatic finish_frame(input int exp_windows);
        bit seen = 1'b0;
        pv = 1'b0;
        wr = 1'b1;
        for (int k = 0; k < 40 && !seen; k++) begin
            if (o_frame_done === 1'b1) seen = 1'b1;
            else step();
        end
        chk("frame_done_seen", seen, 1'b1);
        chk("window_count", n_win, exp_windows);
        chk("sb_drained", sb.size(), 0);
        step();
        chk("idle_after_done", {o_busy, o_frame_done}, 2'b00);
    endtask

    initial begin
        sel = 1'b0; cur_w = W_A; mr = 0; mc = 0;
        rst = 1'b1; start_s = 1'b0; pv = 1'b1; wr = 1'b0; pd = '0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_pix_ready", a_pix_ready, 1'b0);
        chk("rst_win_valid", a_win_valid, 1'b0);
        chk("rst_busy_done", {a_busy, a_frame_done}, 2'b00);
        chk("rst_win_data", a_win_data, '0);
        chk("rst_row_col", {a_row, a_col}, 4'b0000);
        chk("rst_stall", a_stall, 32'd0);
        chk("rst_b_outputs", {b_pix_ready, b_win_valid, b_busy, b_frame_done}, 4'b0000);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("idle_no_ready", o_pix_ready, 1'b0);
        end
        pv = 1'b0;

        // Sequential 0..15, consumer always ready.
        begin_frame(1'b0);
        for (int i = 0; i < 16; i++) begin
            pv = 1'b1;
            pd = PW'(i);
            step();
            chk("pix_accepted", acc, 1'b1);
            chk("emit_latency", o_win_valid, ((i / 4) >= 2) && ((i % 4) >= 2));
            chk("no_early_done", o_frame_done, 1'b0);
            if (i == 10) begin
                chk("first_win_data", o_win_data,
                    {8'd10, 8'd9, 8'd8, 8'd6, 8'd5, 8'd4, 8'd2, 8'd1, 8'd0});
                chk("first_win_center", {o_row, o_col}, {32'd1, 32'd1});
            end
            if (i == 15) chk("last_win_center", {o_row, o_col}, {32'd2, 32'd2});
        end
        pv = 1'b0;
        step();
        chk("frame_done_pulse", o_frame_done, 1'b1);
        chk("window_count", n_win, 4);
        chk("sb_drained", sb.size(), 0);
        step();
        chk("done_one_cycle", {o_busy, o_frame_done}, 2'b00);

        // Backpressure on the first window for five cycles.
        begin_frame(1'b0);
        for (int i = 0; i < 10; i++) begin
            pv = 1'b1; pd = PW'(i);
            step();
        end
        pd = PW'(10); wr = 1'b0;
        step();
        chk("stall_win_valid", o_win_valid, 1'b1);
        held = o_win_data;
        for (int k = 0; k < 5; k++) begin
            pv = 1'b1; pd = PW'(11);
            #1;
            chk("stall_pix_ready", o_pix_ready, 1'b0);
            step();
            chk("stall_hold", o_win_data, held);
        end
`ifdef CONV_SEQ_STALL_CNT_EN
        chk("stall_cycles", o_stall, 32'd5);
`else
        chk("stall_cycles", o_stall, 32'd0);
`endif
        wr = 1'b1;
        for (int i = 11; i < 16; i++) begin
            pv = 1'b1; pd = PW'(i);
            step();
            chk("post_stall_accept", acc, 1'b1);
        end
        finish_frame(4);

        // Reset in the middle of a frame.
        begin_frame(1'b0);
        for (int i = 0; i < 10; i++) begin
            pv = 1'b1; pd = PW'(i);
            step();
        end
        pv = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_state", {o_busy, o_win_valid, o_pix_ready}, 3'b000);
        sb.delete();
        n_win = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("midrst_quiet", {o_frame_done, o_win_valid, o_busy}, 3'b000);
        end
        begin_frame(1'b0);
        feed(16, 0, 0, 1'b0, 0);
        finish_frame(4);

        // Reset wins over a simultaneous start.
        rst = 1'b1; start_s = 1'b1;
        step();
        rst = 1'b0; start_s = 1'b0;
        chk("rst_over_start", o_busy, 1'b0);
        step();
        chk("rst_over_start_idle", o_busy, 1'b0);

        // start pulsed while running is ignored.
        begin_frame(1'b0);
        for (int i = 0; i < 6; i++) begin
            pv = 1'b1; pd = PW'(i);
            step();
        end
        start_s = 1'b1; pv = 1'b1; pd = PW'(6);
        step();
        start_s = 1'b0;
        chk("start_in_run_accept", acc, 1'b1);
        chk("start_in_run_busy", o_busy, 1'b1);
        feed(9, 0, 0, 1'b0, 7);
        finish_frame(4);

        // Random gaps, random backpressure, random data.
        begin_frame(1'b0);
        feed(W_A * H_A, 50, 30, 1'b1, 0);
        finish_frame((W_A - 2) * (H_A - 2));
        for (int f = 0; f < 2; f++) begin
            begin_frame(1'b1);
            feed(W_B * H_B, 50, 30, 1'b1, 0);
            finish_frame((W_B - 2) * (H_B - 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
